// File: rtl/rv32i_types.sv
// Shared RV32 type definitions: M-extension funct3 encodings and the
// execute-stage multiply/divide unit state encoding.
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_t;

  // High-half multiplies and signed divides read operand signs from funct3.
  function automatic logic op_is_signed_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_returns_rem(input muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Signed (XLEN+1)x(XLEN+1) multiplier. MUL_STAGES-1 internal register stages;
// the result register in ex_muldiv forms the final stage.
module mul_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic signed [XLEN:0]   a_i,
  input  logic signed [XLEN:0]   b_i,
  output logic                   valid_o,
  output logic [2*XLEN-1:0]      prod_o
);

  localparam int DEPTH = MUL_STAGES - 1;

  // Only the low 2*XLEN product bits are ever selected, and those are exact
  // when both operands are sign-extended to 2*XLEN bits first.
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod_c;

  assign a_ext  = {{(XLEN-1){a_i[XLEN]}}, a_i};
  assign b_ext  = {{(XLEN-1){b_i[XLEN]}}, b_i};
  assign prod_c = a_ext * b_ext;

  generate
    if (DEPTH == 0) begin : g_comb
      assign prod_o  = prod_c;
      assign valid_o = valid_i;
    end else begin : g_pipe
      logic [2*XLEN-1:0] prod_q [DEPTH];
      logic [DEPTH-1:0]  valid_q;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's old value, giving a true shift register.
      always_ff @(posedge clk) begin
        if (clear_i) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= valid_i;
          for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
        end
      end

      // NOTE: the product array carries no reset; the valid chain alone
      // decides whether a stage holds meaningful data.
      always_ff @(posedge clk) begin
        prod_q[0] <= prod_c;
        for (int i = 1; i < DEPTH; i++) prod_q[i] <= prod_q[i-1];
      end

      assign prod_o  = prod_q[DEPTH-1];
      assign valid_o = valid_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute-stage unit: pipelined multiply, iterative restoring divide.
// Define MULDIV_EARLY_OUT_EN to finish divides with |a| < |b| in one cycle.
module ex_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  muldiv_op_t      op_in;
  muldiv_op_t      op_sel;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] dvsr_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [CNT_W-1:0] cnt_q;

  assign op_in  = muldiv_op_t'(op);
  assign op_sel = (state_q == MD_IDLE) ? op_in : op_q;

  assign done   = (state_q == MD_DONE) && !flush;
  assign stall  = start && !done;
  assign result = result_q;

  logic accept;
  assign accept = (state_q == MD_IDLE) && start && !flush;

  // Multiply operand extension and result selection.
  logic              mul_a_sx;
  logic              mul_b_sx;
  logic              mul_valid;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a_sx = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) && a[XLEN-1];
  assign mul_b_sx = (op_in == OP_MULH) && b[XLEN-1];
  assign mul_res  = (op_sel == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  mul_pipe #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk     (clk),
    .clear_i (rst || flush),
    .valid_i (accept && !op[2]),
    .a_i     ({mul_a_sx, a}),
    .b_i     ({mul_b_sx, b}),
    .valid_o (mul_valid),
    .prod_o  (mul_prod)
  );

  // Divide operand conditioning and single-cycle special cases.
  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_by_zero;
  logic            div_ovf;
  logic            early_out;
  logic            div_special;
  logic [XLEN-1:0] special_res;

  assign div_signed  = op_is_signed_div(op_in);
  assign a_neg       = div_signed && a[XLEN-1];
  assign b_neg       = div_signed && b[XLEN-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = (b == '0);
  assign div_ovf     = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  assign div_special = div_by_zero || div_ovf || early_out;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = op_returns_rem(op_in) ? a : '1;
    end else if (div_ovf) begin
      special_res = op_returns_rem(op_in) ? '0 : a;
    end else if (early_out) begin
      special_res = op_returns_rem(op_in) ? a : '0;
    end
  end

  // One restoring step: the remainder stays below the divisor, so the
  // shifted trial value fits in XLEN+1 bits and the borrow is diff's MSB.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quot_nxt;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  assign rem_sh   = {rem_q, quot_q[XLEN-1]};
  assign diff     = rem_sh - {1'b0, dvsr_q};
  assign fits     = !diff[XLEN];
  assign rem_nxt  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nxt = {quot_q[XLEN-2:0], fits};
  assign quot_fix = q_neg_q ? -quot_nxt : quot_nxt;
  assign rem_fix  = r_neg_q ? -rem_nxt : rem_nxt;
  assign div_res  = op_returns_rem(op_q) ? rem_fix : quot_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      result_q <= '0;
    end else if (flush) begin
      state_q <= MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q <= op_in;
            if (!op[2]) begin
              if (MUL_STAGES == 1) begin
                result_q <= mul_res;
                state_q  <= MD_DONE;
              end else begin
                state_q <= MD_MUL;
              end
            end else if (div_special) begin
              result_q <= special_res;
              state_q  <= MD_DONE;
            end else begin
              rem_q   <= '0;
              quot_q  <= a_mag;
              dvsr_q  <= b_mag;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= MD_DIV;
            end
          end
        end
        MD_MUL: begin
          if (mul_valid) begin
            result_q <= mul_res;
            state_q  <= MD_DONE;
          end
        end
        MD_DIV: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= div_res;
            state_q  <= MD_DONE;
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv (XLEN=32, MUL_STAGES=2); latencies are
// counted from the cycle start is raised. Honours MULDIV_EARLY_OUT_EN.
module tb_ex_muldiv;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(
    .XLEN       (XLEN),
    .MUL_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start now (cycle T) and wait for done; returns inside the done
  // cycle with start still high, as EX would hold it.
  task automatic issue(input string tag, input logic [2:0] o, input logic [XLEN-1:0] av,
                       input logic [XLEN-1:0] bv, input logic [XLEN-1:0] exp, input int lat);
    int k;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    #1;
    check({tag, "_stall_T"}, stall, 1'b1);
    for (k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (stall !== 1'b1) check({tag, "_stall_busy"}, stall, 1'b1);
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_res"}, result, exp);
    check({tag, "_stall_done"}, stall, 1'b0);
  endtask

  // Leave the done cycle with start dropped; no second pulse, result held.
  task automatic settle(input string tag, input logic [XLEN-1:0] exp);
    int dups = 0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) dups++;
      step();
    end
    check({tag, "_nodup"}, dups, 0);
    check({tag, "_held"}, result, exp);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    step();

    issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    settle("mul", 32'hFFFF_FFEB);
    issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    settle("mulhu", 32'hFFFF_FFFE);
    issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
    settle("mulhsu", 32'hFFFF_FFFF);
    issue("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    settle("mulh", 32'h4000_0000);

    issue("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    settle("div", 32'hFFFF_FFFA);
    issue("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    settle("rem", 32'hFFFF_FFFE);
    issue("rem_bneg", 3'd6, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    settle("rem_bneg", 32'd2);
    issue("divu", 3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
    settle("divu", 32'h0FFF_FFFF);
    issue("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    settle("remu", 32'd2);

    issue("divu_z", 3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
    settle("divu_z", 32'hFFFF_FFFF);
    issue("remu_z", 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
    settle("remu_z", 32'h1234_5678);
    issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    settle("div_ovf", 32'h8000_0000);
    issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    settle("rem_ovf", 32'h0);

    issue("divu_small", 3'd5, 32'd5, 32'd9, 32'h0, EO_LAT);
    settle("divu_small", 32'h0);
    issue("rem_small", 3'd6, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, EO_LAT);
    settle("rem_small", 32'hFFFF_FFFB);

    // Flush mid-divide at T+10, new MUL accepted at T+11.
    begin
      int seen = 0;
      start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done) seen++;
      end
      flush = 1'b1;
      #1;
      if (done) seen++;
      step();
      flush = 1'b0;
      check("flush_nodone", seen, 0);
      issue("flush_mul", 3'd0, 32'd6, 32'd7, 32'd42, 2);
      settle("flush_mul", 32'd42);
    end

    // Same sequence with reset; reset also clears the held result.
    begin
      int seen = 0;
      start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done) seen++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      if (done) seen++;
      check("rst_nodone", seen, 0);
      check("rst_mid_result", result, 32'h0);
      issue("rst_mul", 3'd0, 32'd6, 32'd8, 32'd48, 2);
      settle("rst_mul", 32'd48);
    end

    // Flush together with start in IDLE: nothing is accepted.
    begin
      int seen = 0;
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; flush = 1'b1;
      step();
      start = 1'b0; flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (done) seen++;
        step();
      end
      check("flush_idle_nodone", seen, 0);
      check("flush_idle_held", result, 32'd48);
    end

    // Flush during the DONE cycle suppresses the pulse.
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush_done_gate", done, 1'b0);
    step();
    flush = 1'b0;
    start = 1'b0;
    step();

    // Back-to-back: second op raised in the cycle after the first done.
    issue("b2b_1", 3'd0, 32'd3, 32'd5, 32'd15, 2);
    step();
    issue("b2b_2", 3'd0, 32'd9, 32'd9, 32'd81, 2);
    settle("b2b_2", 32'd81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
